// File: rtl/key_debounce_bank.sv
// key_debounce_bank: synchronises and debounces a bank of active-low push-buttons,
// producing clean active-high levels plus one-cycle press/release strobes.

// One debounce channel: four-state FSM with a stability counter.
module key_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_s,      // synchronised key, active-low
    output logic level,
    output logic level_nxt,  // next-state level, lets the bank register key_any in step
    output logic press,
    output logic rel
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, rel_nxt;

    // State, counter and registered outputs; reset drops any pending transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
        end
    end

    // Next-state logic: counter restarts on every new excursion and never wraps,
    // because reaching CNT_MAX always leaves the wait state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = HELD;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// Bank top: shared two-flop synchroniser, array of channels, registered key_any.
module key_debounce_bank #(
    parameter int N_KEYS          = 5,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              key_any
);
    logic [N_KEYS-1:0] s1, s2;
    logic [N_KEYS-1:0] level_nxt;

    // Two-flop synchroniser; resets to released so no spurious press at startup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_KEYS; g++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .key_s    (s2[g]),
                .level    (key_level[g]),
                .level_nxt(level_nxt[g]),
                .press    (key_press[g]),
                .rel      (key_release[g])
            );
        end
    endgenerate

    // key_any follows next-state levels so it moves in the same cycle as key_level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_any <= 1'b0;
        else        key_any <= |level_nxt;
    end
endmodule

// File: tb/tb_key_debounce_bank.sv
// Scoreboard bench for key_debounce_bank with DEBOUNCE_CYCLES=4: the stimulus
// pushes expected strobe events, a monitor pops and checks them every cycle.
module tb_key_debounce_bank;
    localparam int N   = 5;
    localparam int LAT = 7;   // DEBOUNCE_CYCLES+3 edges from the first sampling edge

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] key_n = '1;
    logic [N-1:0] key_level, key_press, key_release;
    logic         key_any;

    typedef struct {
        int           cyc;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] level;
    } exp_t;

    exp_t         q[$];
    logic [N-1:0] exp_level = '0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    key_debounce_bank #(.N_KEYS(N), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_any    (key_any)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input logic [N-1:0] p, input logic [N-1:0] r, input logic [N-1:0] l);
        exp_t e;
        e.cyc = cyc + LAT; e.press = p; e.rel = r; e.level = l;
        q.push_back(e);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            exp_level = '0;
            chk("reset_outs", {key_level, key_press, key_release, key_any}, '0);
        end else begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("missed_strobe_cyc", cyc, e.cyc);
                exp_level = e.level;
            end
            if (|(key_press | key_release)) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {key_press, key_release}, '0);
                end else begin
                    e = q.pop_front();
                    chk("strobe_cyc", cyc, e.cyc);
                    chk("press", key_press, e.press);
                    chk("release", key_release, e.rel);
                    exp_level = e.level;
                end
            end
            chk("level", key_level, exp_level);
            chk("any", key_any, |exp_level);
        end
    end

    initial begin
        // 1: reset then idle with all keys released
        tick(3);
        rst_n = 1'b1;
        tick(20);
        // 2: clean press on key 1
        key_n[1] = 1'b0;
        expect_evt(5'b00010, 5'b00000, 5'b00010);
        tick(12);
        // 3: bouncing key 2, every excursion shorter than the debounce window
        repeat (5) begin
            key_n[2] = 1'b0; tick(3);
            key_n[2] = 1'b1; tick(2);
        end
        tick(6);
        // 4: bouncy release of key 1 (1,1,0,0 then stable 1)
        key_n[1] = 1'b1; tick(2);
        key_n[1] = 1'b0; tick(2);
        key_n[1] = 1'b1;
        expect_evt(5'b00000, 5'b00010, 5'b00000);
        tick(12);
        // 5: simultaneous press of keys 0 and 4, then simultaneous release
        key_n[0] = 1'b0; key_n[4] = 1'b0;
        expect_evt(5'b10001, 5'b00000, 5'b10001);
        tick(12);
        key_n[0] = 1'b1; key_n[4] = 1'b1;
        expect_evt(5'b00000, 5'b10001, 5'b00000);
        tick(12);
        // 6: reset during third cycle of PRESS_WAIT on key 3, key held through reset
        key_n[3] = 1'b0;
        tick(5);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        expect_evt(5'b01000, 5'b00000, 5'b01000);
        tick(14);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_debounce_bank.md
Name: key_debounce_bank

Overview:
- Front-end conditioning stage for the board's push-buttons.
- Takes the raw active-low key inputs, synchronises them to the system clock and debounces each one independently.
- Produces clean active-high levels plus single-cycle press/release strobes.
- Sits directly upstream of the key-driven register stages. key_level and key_press replace raw inverted keys as their data and load inputs.

Parameters:
- N_KEYS, 5, number of independent key channels.
- DEBOUNCE_CYCLES, 250000, cycles the synchronised input must hold stable before a change is accepted (5 ms at 50 MHz). Legal range is >= 2.
- CNT_W, 18, counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  N_KEYS  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
- key_level  out  N_KEYS  debounced state, active-high (1 = pressed).
- key_press  out  N_KEYS  1-cycle pulse on accepted press.
- key_release  out  N_KEYS  1-cycle pulse on accepted release.
- key_any  out  1  OR of key_level.

Behaviour:
- Reset (async assert, sync release on clk):
  - Synchroniser flops go to 1 (released).
  - All channel FSMs go to IDLE and counters to 0.
  - key_level, key_press, key_release and key_any are all 0.
- Synchroniser: two-flop chain per bit, key_n -> s1 -> s2. Only s2 is used downstream.
- Per-channel FSM states:
  - IDLE: stable released. If s2==0, go to PRESS_WAIT with cnt<=0.
  - PRESS_WAIT:
    - If s2==1 (bounce), return to IDLE with no output.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to HELD, set key_level<=1 and assert key_press for exactly that one cycle.
    - Else cnt<=cnt+1.
  - HELD: stable pressed. If s2==1, go to RELEASE_WAIT with cnt<=0.
  - RELEASE_WAIT:
    - If s2==0, return to HELD with no output.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE, set key_level<=0 and pulse key_release for one cycle.
    - Else cnt<=cnt+1.
- Latency:
  - A clean edge on key_n sampled at clock edge E appears on key_level (and its strobe) registered at edge E+DEBOUNCE_CYCLES+2.
  - This is DEBOUNCE_CYCLES+3 edges counting E itself.
  - Press and release latency are identical.
- Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES cycles produces no change on any output. The counter restarts from 0 on every new excursion.
- Strobes: key_press and key_release are never both high on one channel in the same cycle. Each is high for exactly one cycle per accepted transition.
- Channels are fully independent. Simultaneous events on several keys produce simultaneous strobes on the corresponding bits.
- key_any is registered from the next-state key_level, so it changes in the same cycle as key_level.
- Counter never wraps: it saturates by state exit at DEBOUNCE_CYCLES-1.
- Reset mid-debounce: pending transitions are discarded and no strobe is emitted.
- Key held across reset release: treated as a fresh press. key_press fires DEBOUNCE_CYCLES+3 edges after reset release.
- All outputs are registered; there are no combinational paths from key_n to outputs.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3, N_KEYS=5):
1. Reset, then hold key_n=5'b11111 for 20 cycles -> all outputs remain 0.
2. Drive key_n[1]=0 from edge 10 and hold -> key_level[1] and key_press[1] go high after edge 16. key_press[1] is low again after edge 17. key_level[1] stays 1.
3. Pulse key_n[2]=0 for 3 cycles, then 1, repeated 5 times (bounce) -> key_level[2], key_press[2] and key_release[2] remain 0 throughout.
4. With key 1 held, release key_n[1] with a 2-cycle bounce (1,1,0,0), then hold at 1 -> exactly one key_release[1] pulse, 7 edges after the final stable 1. No extra key_press[1].
5. Press key_n[0] and key_n[4] on the same edge -> key_press[0] and key_press[4] pulse in the same cycle. key_any=1 from that cycle on.
6. Drive key_n[3]=0, assert rst_n=0 on 3rd cycle of PRESS_WAIT, deassert 2 cycles later with key still low:
   - Outputs are 0 during reset.
   - No strobe during reset.
   - key_press[3] pulses 7 edges after reset release.
